// File: rtl/apu_pkg.sv
// Shared APU types and frame-sequencer decode masks.
package apu_pkg;

  typedef logic [2:0] apu_step_t;

  // Bit n of each mask is set when step n clocks that unit.
  localparam logic [7:0] APU_STEP_LEN_MASK   = 8'b01010101;
  localparam logic [7:0] APU_STEP_SWEEP_MASK = 8'b01000100;
  localparam logic [7:0] APU_STEP_ENV_MASK   = 8'b10000000;

endpackage

// File: rtl/apu_step_strobe.sv
// Step strobe source: falling edge of the DIV tap, or the test-mode
// prescaler wrap when t1_nt2 is high.
module apu_step_strobe #(
  parameter int FAST_DIV = 16
) (
  input  logic apuv_4mhz,
  input  logic apu_reset,
  input  logic div_tap,
  input  logic t1_nt2,
  output logic adv
);

  localparam int            PW   = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(FAST_DIV - 1);

  logic          div_q;
  logic [PW-1:0] presc_q, presc_d;

  // Tap history runs regardless of power or test mode, so an edge landing
  // on a mode switch is still seen once the tap path is selected again.
  always_ff @(posedge apuv_4mhz) begin
    if (apu_reset) div_q <= 1'b0;
    else           div_q <= div_tap;
  end

  // Prescaler restarts from zero whenever test mode is left.
  always_comb begin
    presc_d = '0;
    if (t1_nt2) presc_d = presc_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge apuv_4mhz) begin
    if (apu_reset) presc_q <= '0;
    else           presc_q <= presc_d;
  end

  assign adv = t1_nt2 ? (presc_q == PMAX) : (div_q & ~div_tap);

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: 8-step counter driven by the step strobe, producing
// one-cycle length / sweep / envelope clocks for the channel blocks.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int FAST_DIV = 16
) (
  input  logic       apuv_4mhz,
  input  logic       apu_reset,
  input  logic       apu_on,
  input  logic       div_tap,
  input  logic       t1_nt2,
  output logic [2:0] step,
  output logic       len_tick,
  output logic       sweep_tick,
  output logic       env_tick,
  output logic       len_skip
);

  logic      adv;
  apu_step_t step_q, step_d;
  logic      len_q, len_d;
  logic      sweep_q, sweep_d;
  logic      env_q, env_d;

  apu_step_strobe #(.FAST_DIV(FAST_DIV)) u_strobe (
    .apuv_4mhz (apuv_4mhz),
    .apu_reset (apu_reset),
    .div_tap   (div_tap),
    .t1_nt2    (t1_nt2),
    .adv       (adv)
  );

  // Next state: ticks decode the step being executed (old step value);
  // power-off parks the counter at 0 and suppresses every tick.
  always_comb begin
    step_d  = step_q;
    len_d   = 1'b0;
    sweep_d = 1'b0;
    env_d   = 1'b0;
    if (!apu_on) begin
      step_d = '0;
    end else if (adv) begin
      step_d  = step_q + 3'd1;
      len_d   = APU_STEP_LEN_MASK[step_q];
      sweep_d = APU_STEP_SWEEP_MASK[step_q];
      env_d   = APU_STEP_ENV_MASK[step_q];
    end
  end

  // Step counter and pulse registers; reset overrides any strobe.
  always_ff @(posedge apuv_4mhz) begin
    if (apu_reset) begin
      step_q  <= '0;
      len_q   <= 1'b0;
      sweep_q <= 1'b0;
      env_q   <= 1'b0;
    end else begin
      step_q  <= step_d;
      len_q   <= len_d;
      sweep_q <= sweep_d;
      env_q   <= env_d;
    end
  end

  assign step       = step_q;
  assign len_tick   = len_q;
  assign sweep_tick = sweep_q;
  assign env_tick   = env_q;
  assign len_skip   = step_q[0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer (FAST_DIV = 16).
module tb_apu_frame_sequencer;

  logic       clk = 1'b0;
  logic       apu_reset, apu_on, div_tap, t1_nt2;
  logic [2:0] step;
  logic       len_tick, sweep_tick, env_tick, len_skip;

  int asserts = 0;
  int fails   = 0;

  apu_frame_sequencer #(.FAST_DIV(16)) dut (
    .apuv_4mhz  (clk),
    .apu_reset  (apu_reset),
    .apu_on     (apu_on),
    .div_tap    (div_tap),
    .t1_nt2     (t1_nt2),
    .step       (step),
    .len_tick   (len_tick),
    .sweep_tick (sweep_tick),
    .env_tick   (env_tick),
    .len_skip   (len_skip)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle past the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one falling edge of the tap; capture outputs in the cycle after
  // the strobe, and whether the ticks are all low one cycle later.
  task automatic pulse_tap(output logic l, output logic s, output logic e,
                           output logic [2:0] st, output logic quiet);
    div_tap = 1'b1;
    cyc();
    cyc();
    div_tap = 1'b0;
    cyc();
    l = len_tick; s = sweep_tick; e = env_tick; st = step;
    cyc();
    quiet = !(len_tick | sweep_tick | env_tick);
  endtask

  task automatic do_reset();
    apu_reset = 1'b1;
    apu_on    = 1'b0;
    div_tap   = 1'b0;
    t1_nt2    = 1'b0;
    cyc();
    cyc();
    apu_reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    asserts++;
    if (step !== 3'd0) begin fails++; $display("FAIL reset_step got %0d want 0", step); end
    asserts++;
    if ({len_tick, sweep_tick, env_tick} !== 3'b000) begin
      fails++; $display("FAIL reset_ticks got %b want 000", {len_tick, sweep_tick, env_tick});
    end
    asserts++;
    if (len_skip !== 1'b0) begin fails++; $display("FAIL reset_len_skip got %b want 0", len_skip); end
  endtask

  task automatic test_sequence();
    // Expected outputs after edges 1..8 (index 0..7).
    int exp_len[8]   = '{1, 0, 1, 0, 1, 0, 1, 0};
    int exp_sweep[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
    int exp_env[8]   = '{0, 0, 0, 0, 0, 0, 0, 1};
    int exp_step[8]  = '{1, 2, 3, 4, 5, 6, 7, 0};
    int exp_skip[8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
    logic l, s, e, q;
    logic [2:0] st;
    apu_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse_tap(l, s, e, st, q);
      asserts++;
      if ({l, s, e} !== {exp_len[i][0], exp_sweep[i][0], exp_env[i][0]}) begin
        fails++;
        $display("FAIL seq_ticks edge %0d got len/sw/env %b%b%b want %0d%0d%0d",
                 i + 1, l, s, e, exp_len[i], exp_sweep[i], exp_env[i]);
      end
      asserts++;
      if (st !== exp_step[i][2:0]) begin
        fails++; $display("FAIL seq_step edge %0d got %0d want %0d", i + 1, st, exp_step[i]);
      end
      asserts++;
      if (q !== 1'b1) begin fails++; $display("FAIL seq_width edge %0d tick still high", i + 1); end
      asserts++;
      if (len_skip !== exp_skip[i][0]) begin
        fails++; $display("FAIL seq_len_skip edge %0d got %b want %0d", i + 1, len_skip, exp_skip[i]);
      end
    end
  endtask

  task automatic test_power_off();
    logic l, s, e, q;
    logic [2:0] st;
    apu_on = 1'b1;
    for (int i = 0; i < 21; i++) pulse_tap(l, s, e, st, q);
    asserts++;
    if (step !== 3'd5) begin fails++; $display("FAIL pwr_pre_step got %0d want 5", step); end
    apu_on = 1'b0;
    cyc();
    asserts++;
    if (step !== 3'd0) begin fails++; $display("FAIL pwr_off_step got %0d want 0", step); end
    for (int i = 0; i < 4; i++) begin
      pulse_tap(l, s, e, st, q);
      asserts++;
      if ({l, s, e, st} !== 6'b000_000) begin
        fails++; $display("FAIL pwr_off_edge %0d got ticks %b%b%b step %0d want 000 step 0", i, l, s, e, st);
      end
    end
    apu_on = 1'b1;
    pulse_tap(l, s, e, st, q);
    asserts++;
    if ({l, s, e} !== 3'b100 || st !== 3'd1) begin
      fails++; $display("FAIL pwr_on_first got ticks %b%b%b step %0d want 100 step 1", l, s, e, st);
    end
  endtask

  task automatic test_powerup_held_tap();
    int extra;
    apu_on  = 1'b0;
    div_tap = 1'b1;
    cyc(); cyc(); cyc();
    apu_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      asserts++;
      if ({len_tick, sweep_tick, env_tick} !== 3'b000) begin
        fails++; $display("FAIL held_pre cycle %0d got ticks %b%b%b want 000", i, len_tick, sweep_tick, env_tick);
      end
    end
    div_tap = 1'b0;
    cyc();
    asserts++;
    if (len_tick !== 1'b1 || step !== 3'd1) begin
      fails++; $display("FAIL held_edge got len %b step %0d want 1 step 1", len_tick, step);
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (len_tick) extra++;
    end
    asserts++;
    if (extra !== 0) begin fails++; $display("FAIL held_extra got %0d extra len ticks want 0", extra); end
  endtask

  task automatic test_fast_mode();
    int k;
    logic el, es, ee;
    logic [2:0] est;
    do_reset();
    apu_on = 1'b1;
    t1_nt2 = 1'b1;
    for (int c = 1; c <= 128; c++) begin
      div_tap = 1'($urandom_range(0, 1));
      cyc();
      el = 1'b0; es = 1'b0; ee = 1'b0;
      if (c % 16 == 0) begin
        k  = (c / 16 - 1) % 8;
        el = (k % 2 == 0);
        es = (k == 2 || k == 6);
        ee = (k == 7);
      end
      est = 3'((c / 16) % 8);
      asserts++;
      if ({len_tick, sweep_tick, env_tick} !== {el, es, ee}) begin
        fails++; $display("FAIL fast_ticks cycle %0d got %b%b%b want %b%b%b",
                          c, len_tick, sweep_tick, env_tick, el, es, ee);
      end
      asserts++;
      if (step !== est) begin fails++; $display("FAIL fast_step cycle %0d got %0d want %0d", c, step, est); end
    end
    t1_nt2 = 1'b0;
  endtask

  task automatic test_collision();
    logic l, s, e, q;
    logic [2:0] st;
    // Power drop on the strobe cycle.
    do_reset();
    apu_on = 1'b1;
    pulse_tap(l, s, e, st, q);
    pulse_tap(l, s, e, st, q);
    div_tap = 1'b1;
    cyc(); cyc();
    div_tap = 1'b0;
    apu_on  = 1'b0;
    cyc();
    asserts++;
    if ({len_tick, sweep_tick, env_tick} !== 3'b000 || step !== 3'd0) begin
      fails++; $display("FAIL coll_power got ticks %b%b%b step %0d want 000 step 0",
                        len_tick, sweep_tick, env_tick, step);
    end
    // Reset on the strobe cycle.
    do_reset();
    apu_on = 1'b1;
    pulse_tap(l, s, e, st, q);
    pulse_tap(l, s, e, st, q);
    div_tap = 1'b1;
    cyc(); cyc();
    div_tap   = 1'b0;
    apu_reset = 1'b1;
    cyc();
    apu_reset = 1'b0;
    asserts++;
    if ({len_tick, sweep_tick, env_tick} !== 3'b000 || step !== 3'd0) begin
      fails++; $display("FAIL coll_reset got ticks %b%b%b step %0d want 000 step 0",
                        len_tick, sweep_tick, env_tick, step);
    end
    // Reset while a pulse is high.
    apu_on  = 1'b1;
    div_tap = 1'b1;
    cyc(); cyc();
    div_tap = 1'b0;
    cyc();
    asserts++;
    if (len_tick !== 1'b1) begin fails++; $display("FAIL midpulse_setup got len %b want 1", len_tick); end
    apu_reset = 1'b1;
    cyc();
    apu_reset = 1'b0;
    asserts++;
    if ({len_tick, step} !== 4'b0_000) begin
      fails++; $display("FAIL midpulse_reset got len %b step %0d want 0 step 0", len_tick, step);
    end
  endtask

  initial begin
    apu_reset = 1'b1; apu_on = 1'b0; div_tap = 1'b0; t1_nt2 = 1'b0;
    test_reset();
    test_sequence();
    test_power_off();
    test_powerup_held_tap();
    test_fast_mode();
    test_collision();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
